// File: rtl/sprite_blitter.sv
// Sprite renderer: beam position -> sprite ROM address, palette lookup, fade/blink
// controller, and registered 4:4:4 RGB with a coverage flag for the compositor.
module sprite_blitter #(
  parameter int SPRITE_W     = 240,
  parameter int SPRITE_H     = 64,
  parameter int IDX_BITS     = 2,
  parameter int ROM_LAT      = 1,
  parameter int SCALE        = 0,
  parameter int TRANSP_IDX   = 0,
  parameter int FADE_FRAMES  = 4,
  parameter int BLINK_FRAMES = 30,
  localparam int ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                vga_clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                frame_start,
  input  logic                start,
  input  logic                clear,
  input  logic                blink_en,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [IDX_BITS-1:0] rom_q,
  output logic [IDX_BITS-1:0] palette_index,
  input  logic [3:0]          pal_red,
  input  logic [3:0]          pal_green,
  input  logic [3:0]          pal_blue,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                pixel_on,
  output logic                active
);

  localparam int CNT_MAX = (FADE_FRAMES > BLINK_FRAMES) ? FADE_FRAMES : BLINK_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic signed [10:0] W_LIM = 11'(SPRITE_W << SCALE);
  localparam logic signed [10:0] H_LIM = 11'(SPRITE_H << SCALE);

  typedef enum logic [1:0] {IDLE, FADE, SHOWN} state_t;

  // Brightness scale: (c * (lvl+1)) >> 4 on an 8-bit product; lvl 15 is identity.
  function automatic logic [3:0] fade_scale(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = 8'(c) * (8'(lvl) + 8'd1);
    return 4'(prod >> 4);
  endfunction

  logic signed [10:0] rel_x, rel_y;
  logic [9:0]         src_x, src_y;
  logic               hit;

  logic [ROM_LAT-1:0] hit_dly_q, hit_dly_d;
  logic [ROM_LAT-1:0] blank_dly_q, blank_dly_d;
  logic               draw;

  logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               pixel_on_q, pixel_on_d;

  state_t             state_q, state_d;
  logic [3:0]         level_q, level_d;
  logic               visible_q, visible_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Stage 0: geometry and ROM address, combinational from the beam position
  always_comb begin
    rel_x = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x});
    rel_y = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y});
    hit   = !rel_x[10] && (rel_x < W_LIM) && !rel_y[10] && (rel_y < H_LIM);
    src_x = rel_x[9:0] >> SCALE;
    src_y = rel_y[9:0] >> SCALE;
    rom_address = hit ? (ADDR_W'(src_y) * ADDR_W'(SPRITE_W) + ADDR_W'(src_x)) : '0;
  end

  // Delay line keeps hit/blank aligned with rom_q
  always_comb begin
    hit_dly_d   = ROM_LAT'({hit_dly_q, hit});
    blank_dly_d = ROM_LAT'({blank_dly_q, blank});
  end

  // Output stage: transparency, visibility and fade applied to the palette colour
  always_comb begin
    draw = hit_dly_q[ROM_LAT-1] && blank_dly_q[ROM_LAT-1] &&
           (rom_q != IDX_BITS'(TRANSP_IDX)) && visible_q;
    red_d      = draw ? fade_scale(pal_red,   level_q) : 4'd0;
    green_d    = draw ? fade_scale(pal_green, level_q) : 4'd0;
    blue_d     = draw ? fade_scale(pal_blue,  level_q) : 4'd0;
    pixel_on_d = draw;
  end

  // Controller: clear beats start; all level/visible changes land on frame_start edges
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    visible_d = visible_q;
    cnt_d     = cnt_q;
    if (clear) begin
      state_d   = IDLE;
      level_d   = 4'd0;
      visible_d = 1'b0;
      cnt_d     = '0;
    end else if (start) begin
      state_d   = FADE;
      level_d   = 4'd0;
      visible_d = 1'b1;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_d   = 4'd0;
          visible_d = 1'b0;
          cnt_d     = '0;
        end
        FADE: begin
          visible_d = 1'b1;
          if (frame_start) begin
            if (cnt_q == CNT_W'(FADE_FRAMES - 1)) begin
              cnt_d   = '0;
              level_d = level_q + 4'd1;
              if (level_q == 4'd14) state_d = SHOWN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SHOWN: begin
          level_d = 4'd15;
          if (!blink_en) begin
            visible_d = 1'b1;
            cnt_d     = '0;
          end else if (frame_start) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
              cnt_d     = '0;
              visible_d = !visible_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hit_dly_q   <= '0;
      blank_dly_q <= '0;
      red_q       <= 4'd0;
      green_q     <= 4'd0;
      blue_q      <= 4'd0;
      pixel_on_q  <= 1'b0;
      state_q     <= IDLE;
      level_q     <= 4'd0;
      visible_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hit_dly_q   <= hit_dly_d;
      blank_dly_q <= blank_dly_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      pixel_on_q  <= pixel_on_d;
      state_q     <= state_d;
      level_q     <= level_d;
      visible_q   <= visible_d;
      cnt_q       <= cnt_d;
    end
  end

  assign palette_index = rom_q;
  assign red           = red_q;
  assign green         = green_q;
  assign blue          = blue_q;
  assign pixel_on      = pixel_on_q;
  assign active        = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: three instances (base, SCALE=1, ROM_LAT=3)
// sharing beam and controller stimulus, each with its own ROM and palette model.
module tb_sprite_blitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic       blank, frame_start, start, clear, blink_en;
  logic       rom_ovr_en;
  logic [1:0] rom_ovr;

  int checks = 0;
  int errors = 0;

  logic [13:0] addr_a, addr_b, addr_c;
  logic [1:0]  rq_a, rq_b, rq_c0, rq_c1, rq_c2, pi_a, pi_b, pi_c;
  logic [3:0]  pr_a, pg_a, pb_a, pr_b, pg_b, pb_b, pr_c, pg_c, pb_c;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic        on_a, on_b, on_c, act_a, act_b, act_c;

  function automatic logic [11:0] pal_f(input logic [1:0] idx);
    case (idx)
      2'd1:    return 12'hF80;
      2'd2:    return 12'h3C5;
      2'd3:    return 12'hAAA;
      default: return 12'h777;
    endcase
  endfunction

  function automatic logic [1:0] rom_f(input logic [13:0] a, input logic en, input logic [1:0] v);
    if (en) return v;
    return a[0] ? 2'd2 : 2'd1;
  endfunction

  always @(posedge clk) begin
    rq_a  <= rom_f(addr_a, rom_ovr_en, rom_ovr);
    rq_b  <= rom_f(addr_b, rom_ovr_en, rom_ovr);
    rq_c0 <= rom_f(addr_c, rom_ovr_en, rom_ovr);
    rq_c1 <= rq_c0;
    rq_c2 <= rq_c1;
  end

  assign {pr_a, pg_a, pb_a} = pal_f(pi_a);
  assign {pr_b, pg_b, pb_b} = pal_f(pi_b);
  assign {pr_c, pg_c, pb_c} = pal_f(pi_c);

  sprite_blitter #(.ROM_LAT(1), .SCALE(0), .FADE_FRAMES(1), .BLINK_FRAMES(2)) u_a (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start), .start(start),
    .clear(clear), .blink_en(blink_en), .rom_address(addr_a), .rom_q(rq_a),
    .palette_index(pi_a), .pal_red(pr_a), .pal_green(pg_a), .pal_blue(pb_a),
    .red(r_a), .green(g_a), .blue(b_a), .pixel_on(on_a), .active(act_a));

  sprite_blitter #(.ROM_LAT(1), .SCALE(1), .FADE_FRAMES(1), .BLINK_FRAMES(2)) u_b (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(10'd0), .pos_y(10'd0), .frame_start(frame_start), .start(start),
    .clear(clear), .blink_en(blink_en), .rom_address(addr_b), .rom_q(rq_b),
    .palette_index(pi_b), .pal_red(pr_b), .pal_green(pg_b), .pal_blue(pb_b),
    .red(r_b), .green(g_b), .blue(b_b), .pixel_on(on_b), .active(act_b));

  sprite_blitter #(.ROM_LAT(3), .SCALE(0), .FADE_FRAMES(1), .BLINK_FRAMES(2)) u_c (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start), .start(start),
    .clear(clear), .blink_en(blink_en), .rom_address(addr_c), .rom_q(rq_c2),
    .palette_index(pi_c), .pal_red(pr_c), .pal_green(pg_c), .pal_blue(pb_c),
    .red(r_c), .green(g_c), .blue(b_c), .pixel_on(on_c), .active(act_c));

  typedef struct {
    logic [9:0]  x, y;
    logic        blank, ovr_en;
    logic [1:0]  ovr;
    logic [13:0] addr;
    logic        on;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
  endtask

  bit exp_bl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    vecs[0]  = '{x:200,  y:208, blank:1, ovr_en:0, ovr:0, addr:0,     on:1, rgb:12'hF80};
    vecs[1]  = '{x:439,  y:208, blank:1, ovr_en:0, ovr:0, addr:239,   on:1, rgb:12'h3C5};
    vecs[2]  = '{x:440,  y:208, blank:1, ovr_en:0, ovr:0, addr:0,     on:0, rgb:12'h000};
    vecs[3]  = '{x:199,  y:208, blank:1, ovr_en:0, ovr:0, addr:0,     on:0, rgb:12'h000};
    vecs[4]  = '{x:201,  y:209, blank:1, ovr_en:0, ovr:0, addr:241,   on:1, rgb:12'h3C5};
    vecs[5]  = '{x:439,  y:271, blank:1, ovr_en:0, ovr:0, addr:15359, on:1, rgb:12'h3C5};
    vecs[6]  = '{x:200,  y:272, blank:1, ovr_en:0, ovr:0, addr:0,     on:0, rgb:12'h000};
    vecs[7]  = '{x:205,  y:210, blank:1, ovr_en:1, ovr:0, addr:485,   on:0, rgb:12'h000};
    vecs[8]  = '{x:205,  y:210, blank:0, ovr_en:0, ovr:0, addr:485,   on:0, rgb:12'h000};
    vecs[9]  = '{x:202,  y:208, blank:1, ovr_en:1, ovr:3, addr:2,     on:1, rgb:12'hAAA};
    vecs[10] = '{x:100,  y:100, blank:1, ovr_en:0, ovr:0, addr:0,     on:0, rgb:12'h000};
    vecs[11] = '{x:1023, y:208, blank:1, ovr_en:0, ovr:0, addr:0,     on:0, rgb:12'h000};

    draw_x = 10'd200; draw_y = 10'd208; pos_x = 10'd200; pos_y = 10'd208;
    blank = 1'b1; frame_start = 1'b0; start = 1'b0; clear = 1'b0; blink_en = 1'b0;
    rom_ovr_en = 1'b0; rom_ovr = 2'd0;

    #3;
    chk("reset_rgb", {r_a, g_a, b_a}, 12'h000);
    chk("reset_on", on_a, 1'b0);
    chk("reset_active", act_a, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_hidden", on_a, 1'b0);

    // fade-in from start to fully shown
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_active", act_a, 1'b1);
    tick(); tick();
    chk("fade_l0_on", on_a, 1'b1);
    chk("fade_l0_rgb", {r_a, g_a, b_a}, 12'h000);
    frame_pulse();
    chk("fade_l1_rgb", {r_a, g_a, b_a}, 12'h110);
    repeat (13) frame_pulse();
    chk("fade_l14_rgb", {r_a, g_a, b_a}, 12'hE70);
    frame_pulse();
    chk("fade_l15_rgb", {r_a, g_a, b_a}, 12'hF80);

    // geometry / transparency / blank table, ROM_LAT 1 and 3 side by side
    for (int i = 0; i < 12; i++) begin
      draw_x = vecs[i].x; draw_y = vecs[i].y; blank = vecs[i].blank;
      rom_ovr_en = vecs[i].ovr_en; rom_ovr = vecs[i].ovr;
      #1;
      chk($sformatf("addr_a[%0d]", i), addr_a, vecs[i].addr);
      chk($sformatf("addr_c[%0d]", i), addr_c, vecs[i].addr);
      repeat (4) tick();
      chk($sformatf("on_a[%0d]", i), on_a, vecs[i].on);
      chk($sformatf("rgb_a[%0d]", i), {r_a, g_a, b_a}, vecs[i].rgb);
      chk($sformatf("on_c[%0d]", i), on_c, vecs[i].on);
      chk($sformatf("rgb_c[%0d]", i), {r_c, g_c, b_c}, vecs[i].rgb);
    end
    rom_ovr_en = 1'b0;

    // one-cycle blank gap: must appear exactly ROM_LAT+1 edges later
    draw_x = 10'd200; draw_y = 10'd208; blank = 1'b1;
    repeat (4) tick();
    blank = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) blank = 1'b1;
      chk($sformatf("blank_lat_a[%0d]", k), on_a, (k != 2));
      chk($sformatf("blank_lat_c[%0d]", k), on_c, (k != 4));
    end

    // SCALE=1 instance at origin
    draw_x = 10'd3; draw_y = 10'd5;
    #1;
    chk("scale_addr_481", addr_b, 14'd481);
    tick(); tick();
    chk("scale_on", on_b, 1'b1);
    chk("scale_rgb", {r_b, g_b, b_b}, 12'h3C5);
    draw_x = 10'd480;
    #1;
    chk("scale_miss_addr", addr_b, 14'd0);
    tick(); tick();
    chk("scale_miss_on", on_b, 1'b0);
    draw_x = 10'd479; draw_y = 10'd127;
    #1;
    chk("scale_corner_addr", addr_b, 14'd15359);

    // blink in SHOWN
    draw_x = 10'd200; draw_y = 10'd208;
    blink_en = 1'b1;
    tick(); tick();
    chk("blink[0]", on_a, exp_bl[0]);
    for (int k = 1; k < 5; k++) begin
      frame_pulse();
      chk($sformatf("blink[%0d]", k), on_a, exp_bl[k]);
    end
    frame_pulse();
    frame_pulse();
    chk("blink_off_again", on_a, 1'b0);
    blink_en = 1'b0;
    tick(); tick();
    chk("blink_release_on", on_a, 1'b1);

    // clear wins over start
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("clr_start_active", act_a, 1'b0);
    tick(); tick();
    chk("clr_start_on", on_a, 1'b0);

    // restart mid-fade, then asynchronous reset mid-line
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_active", act_a, 1'b1);
    repeat (3) frame_pulse();
    chk("fade_l3_rgb", {r_a, g_a, b_a}, 12'h320);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("restart_l0_rgb", {r_a, g_a, b_a}, 12'h000);
    chk("restart_l0_on", on_a, 1'b1);
    repeat (2) frame_pulse();
    chk("fade_l2_rgb", {r_a, g_a, b_a}, 12'h210);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_rgb", {r_a, g_a, b_a}, 12'h000);
    chk("async_rst_on", on_a, 1'b0);
    chk("async_rst_active", act_a, 1'b0);
    chk("async_rst_on_c", on_c, 1'b0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_on", on_a, 1'b0);
    chk("post_rst_active", act_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
